gecko_reg_scoreboard: RTL and testbench
=======================================

GECKO_REG_SCOREBOARD -- requirements
Module: gecko_reg_scoreboard

Interface
REQ-001 Parameter COUNTER_WIDTH, default 2, SHALL set the width of each per-register outstanding-write counter; max count CMAX = 2^COUNTER_WIDTH-1.
REQ-002 Parameter INIT_VALUE, default 32'h0, SHALL be the value written to every register during the init sweep.
REQ-003 Port clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port reserve_valid  input  1  decode requests reservation of a destination register.
REQ-006 Port reserve_addr  input  5  register being reserved.
REQ-007 Port reserve_ready  output  1  reservation accepted this cycle.
REQ-008 Port release_valid  input  1  writeback result present; always accepted.
REQ-009 Port release_addr  input  5  register being written back.
REQ-010 Port release_value  input  32  writeback data.
REQ-011 Port flush  input  1  discard all outstanding reservations.
REQ-012 Port rf_write_enable / rf_write_addr / rf_write_value  output  1/5/32  register-file write port.
REQ-013 Port reg_status  output  32 x gecko_reg_status_t  per-register status for decode.
REQ-014 Port init_done  output  1  high once the init sweep completes.
REQ-015 Port underflow_error  output  1  sticky error flag.

Function
REQ-016 FSM states INIT and RUN; INIT -> RUN after sweep address 31 is written; RUN is terminal until rst.
REQ-017 INIT: one register per cycle, addresses 0..31 ascending, rf_write_enable=1, rf_write_value=INIT_VALUE; exactly 32 cycles; init_done=1 in the cycle after address 31.
REQ-018 INIT: reserve_ready=0; release_valid=1 sets underflow_error and is otherwise ignored.
REQ-019 RUN: reserve_ready = (count[reserve_addr] != CMAX) (see REQ-030); combinational, independent of reserve_valid.
REQ-020 Reservation accepted when reserve_valid && reserve_ready; count[reserve_addr] increments next edge; addr 0 accepted with no count change.
REQ-021 RUN release: rf_write_enable=release_valid && release_addr!=0, rf_write_addr=release_addr, rf_write_value=release_value, combinational same cycle; count[release_addr] decrements next edge.
REQ-022 Release with count==0 (addr!=0): counter stays 0, register still written, underflow_error set next edge.
REQ-023 Simultaneous accepted reserve and release to the same addr: count unchanged.
REQ-024 reg_status registered from counters: count==0 VALID, 0<count<CMAX PARTIAL, count==CMAX FULL; register 0 always VALID; reflects updates one cycle after the event.
REQ-025 flush in RUN: all counters 0 next edge, overriding same-cycle reserve/release count effects; a same-cycle release is still written to the register file.
REQ-026 flush in INIT: no effect.

Reset
REQ-027 rst asserted: state=INIT, sweep address=0, all counters 0, underflow_error=0, init_done=0, reg_status all VALID; rst mid-sweep restarts the sweep at address 0.
REQ-028 Outputs during rst: rf_write_enable=0, reserve_ready=0.

Configuration
REQ-029 Macro GECKO_SCOREBOARD_BYPASS_EN selects same-cycle release bypass on reserve_ready.
REQ-030 Defined: reserve_ready also 1 when count==CMAX and release_valid to the same addr this cycle (net count unchanged); undefined: reserve_ready strictly per REQ-019.

Structure
REQ-031 gecko package SHALL hold gecko_reg_status_t including PARTIAL, plus gecko_scoreboard_state_t (INIT, RUN).
REQ-032 Sub-module gecko_reg_counter (one saturating up/down counter with flush) SHALL be instantiated 31 times (regs 1..31).

Verification
REQ-033 Release rst, wait -> rf_write_addr 0..31 on 32 consecutive cycles with value 0, init_done=1 on cycle 33, reg_status all VALID.
REQ-034 RUN, reserve x5 three times -> reg_status[5] PARTIAL, PARTIAL, FULL; fourth reserve sees reserve_ready=0.
REQ-035 x5 FULL, reserve x5 + release x5 (value 32'hDEADBEEF) same cycle -> rf write x5=DEADBEEF; reserve_ready=1 only with GECKO_SCOREBOARD_BYPASS_EN; with it, status stays FULL.
REQ-036 x7 count 0, release x7 -> write occurs, underflow_error=1 next cycle, status VALID.
REQ-037 x3 count 2, flush + release x3 (value 32'h12) same cycle -> x3 written 32'h12, reg_status[3] VALID next cycle.
REQ-038 rst asserted at sweep address 10 -> sweep restarts at 0, init_done low until 32 further writes complete.

Source files
------------

// File: rtl/gecko_reg_scoreboard_pkg.sv
// Shared types for the register scoreboard: per-register status, FSM state and geometry.
package gecko_reg_scoreboard_pkg;

    localparam int unsigned NumRegs   = 32;
    localparam int unsigned AddrWidth = 5;
    localparam int unsigned DataWidth = 32;

    typedef enum logic [1:0] {
        RegValid   = 2'd0,
        RegPartial = 2'd1,
        RegFull    = 2'd2
    } gecko_reg_status_t;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } gecko_scoreboard_state_t;

    function automatic gecko_reg_status_t count_to_status(input logic is_zero, input logic is_max);
        if (is_zero) begin
            return RegValid;
        end else if (is_max) begin
            return RegFull;
        end
        return RegPartial;
    endfunction

endpackage

// File: rtl/gecko_reg_scoreboard_if.sv
// Decode/writeback handshake and register-file write port of the scoreboard.
interface gecko_reg_scoreboard_if;

    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic        reserve_ready;

    logic        release_valid;
    logic [4:0]  release_addr;
    logic [31:0] release_value;

    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_value;

    modport master (
        output reserve_valid,
        output reserve_addr,
        input  reserve_ready,
        output release_valid,
        output release_addr,
        output release_value,
        input  rf_write_enable,
        input  rf_write_addr,
        input  rf_write_value
    );

    modport slave (
        input  reserve_valid,
        input  reserve_addr,
        output reserve_ready,
        input  release_valid,
        input  release_addr,
        input  release_value,
        output rf_write_enable,
        output rf_write_addr,
        output rf_write_value
    );

endinterface

// File: rtl/gecko_reg_counter.sv
// Saturating up/down outstanding-write counter for one register, with flush and
// a registered status derived from the next count.
module gecko_reg_counter
    import gecko_reg_scoreboard_pkg::*;
#(
    parameter int unsigned Width = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              flush_i,
    output logic [Width-1:0]  count_o,
    output gecko_reg_status_t status_o,
    output logic              underflow_o
);

    localparam logic [Width-1:0] CMax = {Width{1'b1}};

    logic [Width-1:0]  count_q, count_d;
    gecko_reg_status_t status_q, status_d;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i && (count_q != CMax)) begin
            count_d = count_q + Width'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
        // Status follows the next count so it lags the event by exactly one cycle.
        status_d = count_to_status(count_d == '0, count_d == CMax);
    end

    assign underflow_o = dec_i && (count_q == '0);
    assign count_o     = count_q;
    assign status_o    = status_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            status_q <= RegValid;
        end else begin
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

endmodule

// File: rtl/gecko_reg_scoreboard.sv
// Register scoreboard: sweeps the register file with INIT_VALUE, then tracks outstanding
// writes per register. Optional GECKO_SCOREBOARD_BYPASS_EN lets a same-cycle release free a full slot.
module gecko_reg_scoreboard
    import gecko_reg_scoreboard_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 2,
    parameter logic [31:0] INIT_VALUE    = 32'h0
) (
    input  logic                              clk,
    input  logic                              rst,
    gecko_reg_scoreboard_if.slave             bus,
    input  logic                              flush,
    output gecko_reg_status_t [NumRegs-1:0]   reg_status,
    output logic                              init_done,
    output logic                              underflow_error
);

    localparam logic [COUNTER_WIDTH-1:0] CMax = {COUNTER_WIDTH{1'b1}};

    gecko_scoreboard_state_t state_q, state_d;
    logic [AddrWidth-1:0]    sweep_addr_q, sweep_addr_d;
    logic                    init_done_q, init_done_d;
    logic                    underflow_q, underflow_d;

    logic [COUNTER_WIDTH-1:0] count [NumRegs];
    gecko_reg_status_t        status_w [NumRegs];
    logic [NumRegs-1:0]       uf;

    logic                     run;
    logic                     ready_raw;
    logic                     reserve_ok;
    logic [COUNTER_WIDTH-1:0] res_count;

    assign run       = (state_q == StRun) && !rst;
    assign res_count = count[bus.reserve_addr];

    always_comb begin
        ready_raw = (res_count != CMax);
`ifdef GECKO_SCOREBOARD_BYPASS_EN
        // A release to the same register nets the count out, so a full slot may still accept.
        if (bus.release_valid && (bus.release_addr == bus.reserve_addr)) begin
            ready_raw = 1'b1;
        end
`endif
    end

    assign bus.reserve_ready = run && ready_raw;
    assign reserve_ok        = bus.reserve_valid && bus.reserve_ready;

    always_comb begin
        bus.rf_write_enable = 1'b0;
        bus.rf_write_addr   = '0;
        bus.rf_write_value  = '0;
        if (!rst) begin
            if (state_q == StInit) begin
                bus.rf_write_enable = 1'b1;
                bus.rf_write_addr   = sweep_addr_q;
                bus.rf_write_value  = INIT_VALUE;
            end else begin
                bus.rf_write_enable = bus.release_valid && (bus.release_addr != '0);
                bus.rf_write_addr   = bus.release_addr;
                bus.rf_write_value  = bus.release_value;
            end
        end
    end

    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign count[i]    = '0;
            assign status_w[i] = RegValid;
            assign uf[i]       = 1'b0;
        end else begin : g_cnt
            logic inc;
            logic dec;
            assign inc = reserve_ok && (bus.reserve_addr == AddrWidth'(i));
            assign dec = run && bus.release_valid && (bus.release_addr == AddrWidth'(i));

            gecko_reg_counter #(
                .Width(COUNTER_WIDTH)
            ) u_counter (
                .clk        (clk),
                .rst        (rst),
                .inc_i      (inc),
                .dec_i      (dec),
                .flush_i    (run && flush),
                .count_o    (count[i]),
                .status_o   (status_w[i]),
                .underflow_o(uf[i])
            );
        end
    end

    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            reg_status[i] = status_w[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        init_done_d  = init_done_q;
        underflow_d  = underflow_q | (|uf);
        if (state_q == StInit) begin
            sweep_addr_d = sweep_addr_q + AddrWidth'(1);
            if (sweep_addr_q == AddrWidth'(NumRegs - 1)) begin
                state_d     = StRun;
                init_done_d = 1'b1;
            end
            // Writeback before the register file is initialised cannot be honoured.
            if (bus.release_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StInit;
            sweep_addr_q <= '0;
            init_done_q  <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            init_done_q  <= init_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign init_done       = init_done_q;
    assign underflow_error = underflow_q;

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Self-checking bench for gecko_reg_scoreboard: register-file writes are scoreboarded,
// counter/status behaviour is checked against a small per-register count model.
module tb_gecko_reg_scoreboard;
    import gecko_reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    gecko_reg_status_t [31:0] reg_status;
    logic init_done;
    logic underflow_error;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q [$];
    int cnt [32];

    gecko_reg_scoreboard_if bus ();

    gecko_reg_scoreboard #(
        .COUNTER_WIDTH(2),
        .INIT_VALUE   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .flush          (flush),
        .reg_status     (reg_status),
        .init_done      (init_done),
        .underflow_error(underflow_error)
    );

    always #5 clk = ~clk;

    // Register-file write scoreboard.
    always @(negedge clk) begin
        if (bus.rf_write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got addr %0d value %h, required no write",
                         bus.rf_write_addr, bus.rf_write_value);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({bus.rf_write_addr, bus.rf_write_value} !== e) begin
                    errors++;
                    $display("FAIL rf_write: got addr %0d value %h, required addr %0d value %h",
                             bus.rf_write_addr, bus.rf_write_value, e[36:32], e[31:0]);
                end
            end
        end
    end

    function automatic gecko_reg_status_t model_status(input int c);
        if (c == 0) return RegValid;
        if (c == 3) return RegFull;
        return RegPartial;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reserve_valid = 1'b0;
        bus.reserve_addr  = '0;
        bus.release_valid = 1'b0;
        bus.release_addr  = '0;
        bus.release_value = '0;
        flush             = 1'b0;
    endtask

    task automatic test_reset();
        gecko_reg_status_t [31:0] all_valid;
        for (int i = 0; i < 32; i++) all_valid[i] = RegValid;
        repeat (2) step();
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd5;
        bus.release_valid = 1'b1;
        bus.release_addr  = 5'd5;
        @(negedge clk);
        checks++;
        if (bus.rf_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_rf_we: got %b required 0", bus.rf_write_enable);
        end
        checks++;
        if (bus.reserve_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", bus.reserve_ready);
        end
        checks++;
        if ({init_done, underflow_error} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b%b required 00", init_done, underflow_error);
        end
        checks++;
        if (reg_status !== all_valid) begin
            errors++;
            $display("FAIL reset_status: got %h required %h", reg_status, all_valid);
        end
        step();
        idle();
    endtask

    task automatic test_init_sweep();
        gecko_reg_status_t [31:0] all_valid;
        for (int i = 0; i < 32; i++) all_valid[i] = RegValid;
        for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), 32'h0});
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.rf_write_enable, bus.rf_write_addr, init_done} !== {1'b1, 5'(k), 1'b0}) begin
                errors++;
                $display("FAIL sweep_%0d: got we %b addr %0d done %b, required we 1 addr %0d done 0",
                         k, bus.rf_write_enable, bus.rf_write_addr, init_done, k);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got %b required 1", init_done);
        end
        checks++;
        if (reg_status !== all_valid) begin
            errors++;
            $display("FAIL init_status: got %h required %h", reg_status, all_valid);
        end
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        step();
    endtask

    task automatic test_reserve_full();
        gecko_reg_status_t exp_st [3];
        exp_st[0] = RegPartial;
        exp_st[1] = RegPartial;
        exp_st[2] = RegFull;
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.reserve_ready !== 1'b1) begin
                errors++;
                $display("FAIL reserve_ready_%0d: got %b required 1", i, bus.reserve_ready);
            end
            step();
            checks++;
            if (reg_status[5] !== exp_st[i]) begin
                errors++;
                $display("FAIL reserve_status_%0d: got %0d required %0d", i, reg_status[5], exp_st[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.reserve_ready !== 1'b0) begin
            errors++;
            $display("FAIL reserve_full_ready: got %b required 0", bus.reserve_ready);
        end
        step();
        idle();
        checks++;
        if (reg_status[5] !== RegFull) begin
            errors++;
            $display("FAIL reserve_full_status: got %0d required %0d", reg_status[5], RegFull);
        end
        cnt[5] = 3;
    endtask

    task automatic test_bypass();
        logic exp_ready;
        gecko_reg_status_t exp_st;
`ifdef GECKO_SCOREBOARD_BYPASS_EN
        exp_ready = 1'b1;
        exp_st    = RegFull;
        cnt[5]    = 3;
`else
        exp_ready = 1'b0;
        exp_st    = RegPartial;
        cnt[5]    = 2;
`endif
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd5;
        bus.release_valid = 1'b1;
        bus.release_addr  = 5'd5;
        bus.release_value = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        checks++;
        if (bus.reserve_ready !== exp_ready) begin
            errors++;
            $display("FAIL bypass_ready: got %b required %b", bus.reserve_ready, exp_ready);
        end
        step();
        idle();
        checks++;
        if (reg_status[5] !== exp_st) begin
            errors++;
            $display("FAIL bypass_status: got %0d required %0d", reg_status[5], exp_st);
        end
    endtask

    task automatic test_underflow();
        bus.release_valid = 1'b1;
        bus.release_addr  = 5'd0;
        bus.release_value = 32'h1;
        step();
        idle();
        checks++;
        if (underflow_error !== 1'b0) begin
            errors++;
            $display("FAIL x0_release_uf: got %b required 0", underflow_error);
        end
        bus.release_valid = 1'b1;
        bus.release_addr  = 5'd7;
        bus.release_value = 32'h0000_0707;
        exp_q.push_back({5'd7, 32'h0000_0707});
        step();
        idle();
        checks++;
        if (underflow_error !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got %b required 1", underflow_error);
        end
        checks++;
        if (reg_status[7] !== RegValid) begin
            errors++;
            $display("FAIL underflow_status: got %0d required %0d", reg_status[7], RegValid);
        end
    endtask

    task automatic test_flush();
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd3;
        repeat (2) step();
        idle();
        checks++;
        if (reg_status[3] !== RegPartial) begin
            errors++;
            $display("FAIL flush_pre_status: got %0d required %0d", reg_status[3], RegPartial);
        end
        flush             = 1'b1;
        bus.release_valid = 1'b1;
        bus.release_addr  = 5'd3;
        bus.release_value = 32'h12;
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd4;
        exp_q.push_back({5'd3, 32'h12});
        step();
        idle();
        checks++;
        if ({reg_status[5], reg_status[4], reg_status[3]} !== {RegValid, RegValid, RegValid}) begin
            errors++;
            $display("FAIL flush_status: got x5 %0d x4 %0d x3 %0d, required all %0d",
                     reg_status[5], reg_status[4], reg_status[3], RegValid);
        end
        for (int i = 0; i < 32; i++) cnt[i] = 0;
    endtask

    task automatic test_back_to_back();
        int ra, la;
        logic rv, lv, exp_ready, acc;
        logic [31:0] lval;
        for (int it = 0; it < 60; it++) begin
            ra   = 8 + int'($urandom_range(0, 3));
            la   = 8 + int'($urandom_range(0, 3));
            rv   = ($urandom_range(0, 3) != 0);
            lv   = ($urandom_range(0, 2) == 0);
            lval = $urandom;
            bus.reserve_valid = rv;
            bus.reserve_addr  = 5'(ra);
            bus.release_valid = lv;
            bus.release_addr  = 5'(la);
            bus.release_value = lval;
            if (lv) exp_q.push_back({5'(la), lval});
            exp_ready = (cnt[ra] != 3);
`ifdef GECKO_SCOREBOARD_BYPASS_EN
            if (lv && (la == ra)) exp_ready = 1'b1;
`endif
            @(negedge clk);
            checks++;
            if (bus.reserve_ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got %b required %b (x%0d count %0d)",
                         it, bus.reserve_ready, exp_ready, ra, cnt[ra]);
            end
            acc = rv && exp_ready;
            if (!(acc && lv && (la == ra))) begin
                if (acc && cnt[ra] < 3) cnt[ra]++;
                if (lv && cnt[la] > 0) cnt[la]--;
            end
            step();
            for (int r = 8; r < 12; r++) begin
                checks++;
                if (reg_status[r] !== model_status(cnt[r])) begin
                    errors++;
                    $display("FAIL b2b_status_%0d_x%0d: got %0d required %0d",
                             it, r, reg_status[r], model_status(cnt[r]));
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_sweep();
        gecko_reg_status_t [31:0] all_valid;
        for (int i = 0; i < 32; i++) all_valid[i] = RegValid;
        rst = 1'b1;
        step();
        for (int k = 0; k < 10; k++) exp_q.push_back({5'(k), 32'h0});
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rf_write_enable !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_rst_write: got we %b pending %0d, required we 0 pending 0",
                     bus.rf_write_enable, exp_q.size());
        end
        checks++;
        if ({init_done, underflow_error} !== 2'b00 || reg_status !== all_valid) begin
            errors++;
            $display("FAIL mid_rst_state: got done %b uf %b status %h, required 0 0 %h",
                     init_done, underflow_error, reg_status, all_valid);
        end
        step();
        for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), 32'h0});
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) begin
                bus.release_valid = 1'b1;
                bus.release_addr  = 5'd9;
                bus.release_value = 32'hBAD0_0009;
                flush             = 1'b1;
            end
            @(negedge clk);
            checks++;
            if ({init_done, bus.rf_write_addr} !== {1'b0, 5'(k)}) begin
                errors++;
                $display("FAIL restart_%0d: got done %b addr %0d, required done 0 addr %0d",
                         k, init_done, bus.rf_write_addr, k);
            end
            step();
            if (k == 5) begin
                idle();
                checks++;
                if (underflow_error !== 1'b1) begin
                    errors++;
                    $display("FAIL init_release_uf: got %b required 1", underflow_error);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: got %b required 1", init_done);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_init_sweep();
        test_reserve_full();
        test_bypass();
        test_underflow();
        test_flush();
        test_back_to_back();
        test_reset_mid_sweep();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL writes_missing: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
